lp_rx_decoder: RTL and testbench

LP_RX_DECODER -- requirements
Module: lp_rx_decoder

---
 rtl/lp_rx_decoder_if.sv | 48 ++++
 rtl/lp_rx_decoder.sv | 316 +++++++++++++++++++++++++++++++
 tb/tb_lp_rx_decoder.sv | 318 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lp_rx_decoder_if.sv
`default_nettype none
// ============================================================================
//  Module      : lp_rx_decoder_if
//  Description : Bundle of the LP receive decoder's line inputs and decoded
//                outputs.
//                master : drives the lines and the enable, observes results
//                slave  : the decoder itself
//  Signals     : lines_enable  decoder enable
//                LP_p_input    asynchronous LP Dp line
//                LP_n_input    asynchronous LP Dn line
//                rx_data       received LPDT byte (qualified by rx_valid)
//                rx_valid      one-cycle pulse per received LPDT byte
//                rx_eot        one-cycle pulse at a clean end of an LPDT burst
//                esc_cmd       last decoded escape entry command (held)
//                esc_cmd_valid one-cycle pulse when esc_cmd updates
//                hs_rqst       one-cycle pulse on an HS request sequence
//                err_sync      one-cycle pulse on stop with a partial byte
//                err_timeout   one-cycle pulse on watchdog expiry
//                active        high outside DISABLED and STOP
//  Revision    : 1.0 - initial release
// ============================================================================
interface lp_rx_decoder_if;
    logic       lines_enable;
    logic       LP_p_input;
    logic       LP_n_input;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_eot;
    logic [7:0] esc_cmd;
    logic       esc_cmd_valid;
    logic       hs_rqst;
    logic       err_sync;
    logic       err_timeout;
    logic       active;

    modport master (
        output lines_enable, LP_p_input, LP_n_input,
        input  rx_data, rx_valid, rx_eot, esc_cmd, esc_cmd_valid,
               hs_rqst, err_sync, err_timeout, active
    );

    modport slave (
        input  lines_enable, LP_p_input, LP_n_input,
        output rx_data, rx_valid, rx_eot, esc_cmd, esc_cmd_valid,
               hs_rqst, err_sync, err_timeout, active
    );
endinterface
`default_nettype wire

// File: rtl/lp_rx_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : lp_rx_decoder
//  Description : Low-power line-state receiver. Synchronizes and deglitches
//                the Dp/Dn pair, then decodes stop / HS request / escape
//                entry / escape command / LPDT byte sequences from changes of
//                the filtered line state.
//  Ports       : clk_sys   single clock, everything on its rising edge
//                rst_n     synchronous active-low reset
//                bus       lp_rx_decoder_if.slave (lines in, results out)
//  Parameters  : FILTER_LEN cycles a synchronized pair must hold (1..15)
//                TIMEOUT    watchdog reload value
//  Revision    : 1.0 - initial release
// ============================================================================
module lp_rx_decoder #(
    parameter int         FILTER_LEN = 2,
    parameter logic [7:0] TIMEOUT    = 8'd255
) (
    input  logic           clk_sys,
    input  logic           rst_n,
    lp_rx_decoder_if.slave bus
);

    // Line states, encoded {p, n}
    localparam logic [1:0] LP11 = 2'b11;
    localparam logic [1:0] LP10 = 2'b10;
    localparam logic [1:0] LP01 = 2'b01;
    localparam logic [1:0] LP00 = 2'b00;

    localparam logic [3:0] FLEN = 4'(FILTER_LEN);

    typedef enum logic [3:0] {
        STATE_DISABLED  = 4'd0,
        STATE_STOP      = 4'd1,
        STATE_HS_RQST   = 4'd2,
        STATE_HS_WAIT   = 4'd3,
        STATE_ESC_10    = 4'd4,
        STATE_ESC_00A   = 4'd5,
        STATE_ESC_01    = 4'd6,
        STATE_ESC_00B   = 4'd7,
        STATE_ESC_CMD   = 4'd8,
        STATE_LPDT      = 4'd9,
        STATE_WAIT_STOP = 4'd10
    } state_t;

    // ------------------------------------------------------------------
    // Two-flop synchronizer, both lines idle high
    // ------------------------------------------------------------------
    logic [1:0] meta_q;
    logic [1:0] sync_q;

    always_ff @(posedge clk_sys) begin
        if (!rst_n) begin
            meta_q <= LP11;
            sync_q <= LP11;
        end else begin
            meta_q <= {bus.LP_p_input, bus.LP_n_input};
            sync_q <= meta_q;
        end
    end

    // ------------------------------------------------------------------
    // Stability filter. cand_q is the most recent synchronized value and
    // stab_q how many consecutive cycles it has been seen (saturating at
    // FLEN). The filtered state takes the candidate on the cycle the count
    // reaches FLEN, giving a pin-to-filtered latency of 2 + FILTER_LEN.
    // ------------------------------------------------------------------
    logic [1:0] cand_q;
    logic [3:0] stab_q;
    logic [1:0] filt_q;
    logic [1:0] filt_prev_q;

    always_ff @(posedge clk_sys) begin
        if (!rst_n) begin
            cand_q      <= LP11;
            stab_q      <= FLEN;
            filt_q      <= LP11;
            filt_prev_q <= LP11;
        end else begin
            filt_prev_q <= filt_q;
            if (sync_q != cand_q) begin
                cand_q <= sync_q;
                stab_q <= 4'd1;
                if (FLEN == 4'd1) begin
                    filt_q <= sync_q;
                end
            end else if (stab_q < FLEN) begin
                stab_q <= stab_q + 4'd1;
                if (stab_q + 4'd1 == FLEN) begin
                    filt_q <= sync_q;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Decoder
    // ------------------------------------------------------------------
    state_t     state_q;
    // Only seven bits are held: the eighth bit of a byte completes it and
    // goes straight to the output register together with these seven.
    logic [6:0] shift_q;
    logic [2:0] bitcnt_q;
    logic       mark_pend_q;   // a mark was seen, waiting for LP-00 to commit
    logic       mark_bit_q;    // value of the pending mark
    logic [7:0] wd_q;

    logic [7:0] rx_data_q;
    logic       rx_valid_q;
    logic       rx_eot_q;
    logic [7:0] esc_cmd_q;
    logic       esc_cmd_valid_q;
    logic       hs_rqst_q;
    logic       err_sync_q;
    logic       err_timeout_q;

    logic       w_event;
    logic       w_is_mark;
    logic [7:0] w_byte_d;
    logic       w_wd_reload;

    assign w_event     = (filt_q != filt_prev_q);
    assign w_is_mark   = (filt_q == LP10) || (filt_q == LP01);
    assign w_byte_d    = {shift_q, mark_bit_q};
    assign w_wd_reload = w_event
                      || (state_q == STATE_STOP)
                      || (state_q == STATE_DISABLED)
                      || (state_q == STATE_HS_WAIT);

    always_ff @(posedge clk_sys) begin
        if (!rst_n) begin
            state_q         <= STATE_DISABLED;
            shift_q         <= 7'd0;
            bitcnt_q        <= 3'd0;
            mark_pend_q     <= 1'b0;
            mark_bit_q      <= 1'b0;
            wd_q            <= TIMEOUT;
            rx_data_q       <= 8'd0;
            rx_valid_q      <= 1'b0;
            rx_eot_q        <= 1'b0;
            esc_cmd_q       <= 8'd0;
            esc_cmd_valid_q <= 1'b0;
            hs_rqst_q       <= 1'b0;
            err_sync_q      <= 1'b0;
            err_timeout_q   <= 1'b0;
        end else begin
            rx_valid_q      <= 1'b0;
            rx_eot_q        <= 1'b0;
            esc_cmd_valid_q <= 1'b0;
            hs_rqst_q       <= 1'b0;
            err_sync_q      <= 1'b0;
            err_timeout_q   <= 1'b0;

            if (!bus.lines_enable) begin
                state_q     <= STATE_DISABLED;
                mark_pend_q <= 1'b0;
                wd_q        <= TIMEOUT;
            end else begin
                case (state_q)
                    STATE_DISABLED: begin
                        shift_q     <= 7'd0;
                        bitcnt_q    <= 3'd0;
                        mark_pend_q <= 1'b0;
                        if (filt_q == LP11) begin
                            state_q <= STATE_STOP;
                        end
                    end

                    // Byte assembly is held clear for as long as we idle in
                    // stop, so every burst starts from an empty register.
                    STATE_STOP: begin
                        shift_q     <= 7'd0;
                        bitcnt_q    <= 3'd0;
                        mark_pend_q <= 1'b0;
                        if (w_event) begin
                            case (filt_q)
                                LP01:    state_q <= STATE_HS_RQST;
                                LP10:    state_q <= STATE_ESC_10;
                                LP00:    state_q <= STATE_WAIT_STOP;
                                default: state_q <= STATE_STOP;
                            endcase
                        end
                    end

                    STATE_HS_RQST: begin
                        if (w_event) begin
                            if (filt_q == LP00) begin
                                state_q   <= STATE_HS_WAIT;
                                hs_rqst_q <= 1'b1;
                            end else if (filt_q == LP11) begin
                                state_q <= STATE_STOP;
                            end else begin
                                state_q <= STATE_WAIT_STOP;
                            end
                        end
                    end

                    STATE_HS_WAIT: begin
                        if (w_event && (filt_q == LP11)) begin
                            state_q <= STATE_STOP;
                        end
                    end

                    STATE_ESC_10: begin
                        if (w_event) begin
                            if (filt_q == LP00)      state_q <= STATE_ESC_00A;
                            else if (filt_q == LP11) state_q <= STATE_STOP;
                            else                     state_q <= STATE_WAIT_STOP;
                        end
                    end

                    STATE_ESC_00A: begin
                        if (w_event) begin
                            if (filt_q == LP01)      state_q <= STATE_ESC_01;
                            else if (filt_q == LP11) state_q <= STATE_STOP;
                            else                     state_q <= STATE_WAIT_STOP;
                        end
                    end

                    STATE_ESC_01: begin
                        if (w_event) begin
                            if (filt_q == LP00)      state_q <= STATE_ESC_00B;
                            else if (filt_q == LP11) state_q <= STATE_STOP;
                            else                     state_q <= STATE_WAIT_STOP;
                        end
                    end

                    STATE_ESC_00B: begin
                        if (w_event) begin
                            if (filt_q == LP11) begin
                                state_q <= STATE_STOP;
                            end else if (w_is_mark) begin
                                state_q     <= STATE_ESC_CMD;
                                mark_pend_q <= 1'b1;
                                mark_bit_q  <= (filt_q == LP10);
                            end else begin
                                state_q <= STATE_WAIT_STOP;
                            end
                        end
                    end

                    // Command and data bits share one decoder; only what
                    // happens on a completed byte and on stop differs.
                    STATE_ESC_CMD, STATE_LPDT: begin
                        if (w_event) begin
                            if (filt_q == LP11) begin
                                // A pending mark followed by stop is not a bit.
                                state_q <= STATE_STOP;
                                if (bitcnt_q != 3'd0) begin
                                    err_sync_q <= 1'b1;
                                end else if (state_q == STATE_LPDT) begin
                                    rx_eot_q <= 1'b1;
                                end
                            end else if (!mark_pend_q) begin
                                if (w_is_mark) begin
                                    mark_pend_q <= 1'b1;
                                    mark_bit_q  <= (filt_q == LP10);
                                end
                            end else if (filt_q == LP00) begin
                                mark_pend_q <= 1'b0;
                                shift_q     <= w_byte_d[6:0];
                                bitcnt_q    <= bitcnt_q + 3'd1;   // 7 wraps to 0
                                if (bitcnt_q == 3'd7) begin
                                    if (state_q == STATE_ESC_CMD) begin
                                        esc_cmd_q       <= w_byte_d;
                                        esc_cmd_valid_q <= 1'b1;
                                        state_q <= (w_byte_d == 8'hE1) ? STATE_LPDT
                                                                       : STATE_WAIT_STOP;
                                    end else begin
                                        rx_data_q  <= w_byte_d;
                                        rx_valid_q <= 1'b1;
                                    end
                                end
                            end else begin
                                // Mark straight into the opposite mark.
                                state_q <= STATE_WAIT_STOP;
                            end
                        end
                    end

                    STATE_WAIT_STOP: begin
                        if (w_event && (filt_q == LP11)) begin
                            state_q <= STATE_STOP;
                        end
                    end

                    default: state_q <= STATE_WAIT_STOP;
                endcase

                // Watchdog. Expiry can only coincide with a cycle without an
                // event, when the case above left the state untouched.
                if (w_wd_reload) begin
                    wd_q <= TIMEOUT;
                end else if (wd_q == 8'd0) begin
                    err_timeout_q <= 1'b1;
                    state_q       <= STATE_WAIT_STOP;
                    wd_q          <= TIMEOUT;
                end else begin
                    wd_q <= wd_q - 8'd1;
                end
            end
        end
    end

    assign bus.rx_data       = rx_data_q;
    assign bus.rx_valid      = rx_valid_q;
    assign bus.rx_eot        = rx_eot_q;
    assign bus.esc_cmd       = esc_cmd_q;
    assign bus.esc_cmd_valid = esc_cmd_valid_q;
    assign bus.hs_rqst       = hs_rqst_q;
    assign bus.err_sync      = err_sync_q;
    assign bus.err_timeout   = err_timeout_q;
    assign bus.active        = (state_q != STATE_DISABLED) && (state_q != STATE_STOP);

endmodule
`default_nettype wire

// File: tb/tb_lp_rx_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lp_rx_decoder
//  Description : Bench for lp_rx_decoder. Line bursts are described as lists
//                of line states; a protocol-level model turns each list into
//                the expected output pulses, which a monitor matches in order
//                against what the decoder produces.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_lp_rx_decoder;

    localparam logic [1:0] LP11 = 2'b11;
    localparam logic [1:0] LP10 = 2'b10;
    localparam logic [1:0] LP01 = 2'b01;
    localparam logic [1:0] LP00 = 2'b00;

    localparam logic [2:0] K_CMD   = 3'd0;
    localparam logic [2:0] K_RX    = 3'd1;
    localparam logic [2:0] K_EOT   = 3'd2;
    localparam logic [2:0] K_HSR   = 3'd3;
    localparam logic [2:0] K_ESYNC = 3'd4;
    localparam logic [2:0] K_ETO   = 3'd5;

    typedef struct packed {
        logic [2:0] kind;
        logic [7:0] data;
    } exp_t;

    logic clk_sys = 1'b0;
    logic rst_n   = 1'b0;
    always #5 clk_sys = ~clk_sys;

    lp_rx_decoder_if bus ();

    lp_rx_decoder #(.FILTER_LEN(2), .TIMEOUT(8'd255)) dut (
        .clk_sys (clk_sys),
        .rst_n   (rst_n),
        .bus     (bus)
    );

    exp_t       expq[$];
    logic [1:0] burst[$];
    int         total  = 0;
    int         bad    = 0;
    bit         mon_en = 1'b0;

    function automatic string kname(input logic [2:0] k);
        case (k)
            K_CMD:   return "esc_cmd_valid";
            K_RX:    return "rx_valid";
            K_EOT:   return "rx_eot";
            K_HSR:   return "hs_rqst";
            K_ESYNC: return "err_sync";
            default: return "err_timeout";
        endcase
    endfunction

    function automatic void push_exp(input logic [2:0] k, input logic [7:0] d);
        exp_t e;
        e.kind = k;
        e.data = d;
        expq.push_back(e);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic check_pulse(input logic [2:0] k, input logic [7:0] d);
        exp_t e;
        total++;
        if (expq.size() == 0) begin
            bad++;
            $display("FAIL unexpected pulse: got %s data=%h, required nothing", kname(k), d);
        end else begin
            e = expq.pop_front();
            if (e.kind != k || e.data != d) begin
                bad++;
                $display("FAIL pulse order: got %s data=%h, required %s data=%h",
                         kname(k), d, kname(e.kind), e.data);
            end
        end
    endtask

    // Monitor: every output pulse consumes the next expected entry.
    always @(negedge clk_sys) begin
        if (mon_en && rst_n) begin
            if (bus.esc_cmd_valid) check_pulse(K_CMD, bus.esc_cmd);
            if (bus.rx_valid)      check_pulse(K_RX, bus.rx_data);
            if (bus.rx_eot)        check_pulse(K_EOT, 8'h00);
            if (bus.hs_rqst)       check_pulse(K_HSR, 8'h00);
            if (bus.err_sync)      check_pulse(K_ESYNC, 8'h00);
            if (bus.err_timeout)   check_pulse(K_ETO, 8'h00);
        end
    end

    // ------------------------------------------------------------------
    // Burst builders
    // ------------------------------------------------------------------
    function automatic void b_entry();
        burst.push_back(LP10);
        burst.push_back(LP00);
        burst.push_back(LP01);
        burst.push_back(LP00);
    endfunction

    // The low n bits of v, most significant first, each as mark then LP-00.
    function automatic void b_bits(input logic [7:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            burst.push_back(v[i] ? LP10 : LP01);
            burst.push_back(LP00);
        end
    endfunction

    function automatic logic [1:0] pick_nonstop();
        case ($urandom_range(0, 2))
            0:       return LP10;
            1:       return LP01;
            default: return LP00;
        endcase
    endfunction

    // ------------------------------------------------------------------
    // Reference model: interprets one burst (the line states between two
    // stop states) at the protocol level.
    // ------------------------------------------------------------------
    task automatic model_burst();
        int         len;
        int         i;
        bit         clean;
        logic       bits[$];
        logic [7:0] acc;
        int         nbytes;
        len   = burst.size();
        clean = 1'b1;
        if (len == 0) return;
        if (burst[0] == LP01) begin
            if (len > 1 && burst[1] == LP00) push_exp(K_HSR, 8'h00);
            return;
        end
        if (len < 4 || burst[0] != LP10 || burst[1] != LP00 ||
            burst[2] != LP01 || burst[3] != LP00) return;
        i = 4;
        while (i < len) begin
            if (i + 1 == len) break;                          // mark, then stop
            if (burst[i + 1] != LP00) begin clean = 1'b0; break; end  // mark to mark
            bits.push_back(burst[i] == LP10);
            i += 2;
        end
        if (bits.size() < 8) begin
            if (clean && bits.size() != 0) push_exp(K_ESYNC, 8'h00);
            return;
        end
        acc = 8'h00;
        for (int k = 0; k < 8; k++) acc = {acc[6:0], bits[k]};
        push_exp(K_CMD, acc);
        if (acc != 8'hE1) return;
        nbytes = (bits.size() - 8) / 8;
        for (int b = 0; b < nbytes; b++) begin
            acc = 8'h00;
            for (int k = 0; k < 8; k++) acc = {acc[6:0], bits[8 + 8 * b + k]};
            push_exp(K_RX, acc);
        end
        if (clean) begin
            if ((bits.size() - 8) % 8 == 0) push_exp(K_EOT, 8'h00);
            else                            push_exp(K_ESYNC, 8'h00);
        end
    endtask

    // Entered and left on a falling edge.
    task automatic set_line(input logic [1:0] s, input int n);
        {bus.LP_p_input, bus.LP_n_input} = s;
        repeat (n) @(negedge clk_sys);
    endtask

    task automatic send_burst();
        model_burst();
        foreach (burst[i]) set_line(burst[i], int'($urandom_range(3, 8)));
        set_line(LP11, int'($urandom_range(8, 14)));
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, " rx_data"}, {24'd0, bus.rx_data}, 32'd0);
        chk({name, " esc_cmd"}, {24'd0, bus.esc_cmd}, 32'd0);
        chk({name, " pulses+active"},
            {25'd0, bus.rx_valid, bus.rx_eot, bus.esc_cmd_valid, bus.hs_rqst,
             bus.err_sync, bus.err_timeout, bus.active}, 32'd0);
    endtask

    initial begin
        #5ms;
        $display("FAIL global time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        logic [1:0] prev;
        logic [1:0] nxt;
        bus.lines_enable = 1'b0;
        bus.LP_p_input   = 1'b1;
        bus.LP_n_input   = 1'b1;
        rst_n            = 1'b0;
        @(negedge clk_sys);
        repeat (4) @(negedge clk_sys);
        chk_all_zero("reset");

        rst_n  = 1'b1;
        mon_en = 1'b1;
        set_line(LP11, 4);
        chk("disabled active", {31'd0, bus.active}, 32'd0);
        bus.lines_enable = 1'b1;
        set_line(LP11, 6);
        chk("stop active", {31'd0, bus.active}, 32'd0);

        // LPDT burst E1, A5, 3C
        burst.delete(); b_entry(); b_bits(8'hE1, 8); b_bits(8'hA5, 8); b_bits(8'h3C, 8);
        send_burst();
        set_line(LP11, 10);
        chk("lpdt burst drained", expq.size(), 32'd0);

        // HS request held 100 cycles in LP-00
        push_exp(K_HSR, 8'h00);
        set_line(LP01, 5);
        set_line(LP00, 10);
        for (int k = 0; k < 9; k++) begin
            chk("hs active", {31'd0, bus.active}, 32'd1);
            set_line(LP00, 10);
        end
        set_line(LP11, 10);
        chk("hs back to stop", {31'd0, bus.active}, 32'd0);
        chk("hs drained", expq.size(), 32'd0);

        // LPDT with three bits of a byte then stop
        burst.delete(); b_entry(); b_bits(8'hE1, 8); b_bits(8'h05, 3);
        send_burst();

        // Non-LPDT command, data marks ignored
        burst.delete(); b_entry(); b_bits(8'h62, 8); b_bits(8'hA5, 8); b_bits(8'h3C, 8);
        send_burst();
        set_line(LP11, 10);
        chk("cmd 62 drained", expq.size(), 32'd0);

        // Single-cycle glitch in stop
        set_line(LP10, 1);
        set_line(LP11, 10);
        chk("glitch ignored", {31'd0, bus.active}, 32'd0);

        // Escape entry then LP-00 held 300 cycles
        push_exp(K_ETO, 8'h00);
        set_line(LP10, 5); set_line(LP00, 5); set_line(LP01, 5);
        set_line(LP00, 150);
        chk("pre-timeout active", {31'd0, bus.active}, 32'd1);
        set_line(LP00, 150);
        chk("timeout seen", expq.size(), 32'd0);
        chk("wait_stop active", {31'd0, bus.active}, 32'd1);
        set_line(LP11, 10);
        chk("timeout back to stop", {31'd0, bus.active}, 32'd0);

        // Reset in the middle of an LPDT byte
        push_exp(K_CMD, 8'hE1);
        burst.delete(); b_entry(); b_bits(8'hE1, 8); b_bits(8'h05, 3); burst.push_back(LP10);
        foreach (burst[i]) set_line(burst[i], 4);
        rst_n = 1'b0;
        @(negedge clk_sys);
        chk_all_zero("mid-burst reset");
        rst_n = 1'b1;
        set_line(LP11, 12);
        chk("mid-burst reset drained", expq.size(), 32'd0);
        burst.delete(); b_entry(); b_bits(8'hE1, 8); b_bits(8'h5A, 8); b_bits(8'hC3, 8);
        send_burst();

        // Randomized bursts
        for (int n = 0; n < 36; n++) begin
            burst.delete();
            case ($urandom_range(0, 4))
                0: begin
                    burst.push_back(LP01);
                    burst.push_back(LP00);
                end
                1, 2: begin
                    b_entry();
                    b_bits(8'hE1, 8);
                    repeat ($urandom_range(0, 3)) b_bits(8'($urandom), 8);
                    if ($urandom_range(0, 1) == 1) b_bits(8'($urandom), int'($urandom_range(1, 7)));
                    if ($urandom_range(0, 2) == 0) burst.push_back($urandom_range(0, 1) == 1 ? LP10 : LP01);
                end
                3: begin
                    b_entry();
                    b_bits(8'($urandom), 8);
                    b_bits(8'($urandom), int'($urandom_range(0, 8)));
                end
                default: begin
                    if ($urandom_range(0, 1) == 1) b_entry();
                    else burst.push_back(pick_nonstop());
                    repeat ($urandom_range(2, 16)) begin
                        prev = burst[$];
                        nxt  = pick_nonstop();
                        while (nxt == prev) nxt = pick_nonstop();
                        burst.push_back(nxt);
                    end
                end
            endcase
            send_burst();
        end

        set_line(LP11, 30);
        chk("final scoreboard drained", expq.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
